cmp_lanes_pipe: RTL and testbench
=================================

// Module: cmp_lanes_pipe
// PURPOSE
//  Parametrised successor of the registered 1-bit neq primitive: N independent lanes of W-bit
//  comparators, run-time selectable op (eq/neq/lt/le/gt/ge), signed or unsigned, LAT-stage
//  pipeline with valid tracking and a stall enable. Target primitive for Reticle compare ops
//  (eq/neq/lt/...) lowered to LUT+FF, checked by the ci directed benches.
// PARAMETERS
//  W       8   operand width per lane, bits (>=1)
//  LANES   4   number of independent comparator lanes (>=1)
//  LAT     1   result latency in enabled cycles (>=1); LAT=1 equals the legacy neq_b_b_b timing
//  SIGNED  0   1: two's-complement compare for lt/le/gt/ge; 0: unsigned. eq/neq unaffected
// PORTS
//  clock      in   1          single clock, all state on posedge
//  reset      in   1          synchronous, active-high
//  en         in   1          1: pipeline advances; 0: every stage holds
//  in_valid   in   1          operands/op valid this cycle
//  op         in   3          cmp_pkg::cmp_op_t, captured with operands
//  a          in   LANES*W    lane i = a[i*W +: W]
//  b          in   LANES*W    lane i = b[i*W +: W]
//  out_valid  out  1          y corresponds to an accepted in_valid beat
//  y          out  LANES      lane i result, 1 = relation holds
//  any_y      out  1          OR of y (registered together with y)
//  hit_cnt    out  16         see CONFIGURATION
// BEHAVIOUR
//  - Reset (sync, high): all stage valids, y, any_y, out_valid, hit_cnt <= 0 on next posedge.
//    Reset mid-flight discards every in-flight beat; no beat accepted in the reset cycle.
//  - Op codes: EQ=0 NEQ=1 LT=2 LE=3 GT=4 GE=5; codes 6,7 -> all lanes y=0 (valid still flows).
//  - Relation is a OP b per lane; SIGNED selects $signed compare, width exactly W, no extension
//    beyond W; lanes never interact.
//  - Stage 1 registers compare result + in_valid when en=1; stages 2..LAT shift when en=1.
//    With en=1 continuously, a beat presented at edge k appears on out_valid/y after edge k+LAT-1
//    (i.e. visible the cycle after LAT posedges).
//  - en=0: all stages, out_valid, y, hit_cnt hold; inputs that cycle ignored (not accepted).
//  - in_valid=0 with en=1: bubble enters; y of a bubble stage is forced 0, out_valid 0.
//  - Fully pipelined: one beat per enabled cycle, no backpressure output, no ready.
//  - any_y = |y, same timing as y; 0 whenever out_valid=0.
// CONFIGURATION
//  - Macro CMP_HIT_CNT_EN.
//    Defined: hit_cnt increments by 1 on each enabled cycle where the newly produced beat has
//    out_valid=1 and any_y=1; saturates at 16'hFFFF; cleared only by reset.
//    Undefined: counter not built, hit_cnt tied to 16'd0; all other behaviour identical.
// STRUCTURE
//  - Package cmp_pkg: typedef enum logic [2:0] cmp_op_t {CMP_EQ..CMP_GE}; localparam
//    CMP_CNT_W = 16.
//  - Sub-module cmp_lane (W, SIGNED): combinational a/b/op -> 1-bit result; instantiated LANES
//    times via generate. Pipeline, valid chain and counter live in top.
// TESTING
//  1 W=1,LANES=1,LAT=1,op=NEQ: (a,b)=(0,0),(1,0),(0,1),(1,1) -> y=0,1,1,0 one cycle later;
//    matches legacy neq.
//  2 W=8,SIGNED=1,op=LT: a=8'hFF(-1), b=8'h01 -> y=1; same with SIGNED=0 -> y=0;
//    op=GE a=b=8'h80 -> y=1.
//  3 LAT=3, en=1, beats on 4 consecutive cycles -> out_valid high 4 cycles starting after 3rd
//    edge, y in order.
//  4 LAT=3, en=0 for 2 cycles mid-stream -> outputs frozen, no beat lost or duplicated;
//    op=6 -> y=0, out_valid=1.
//  5 Reset asserted with 2 beats in flight -> out_valid=0, y=0, hit_cnt=0 next cycle; no stale
//    beat later.
//  6 CMP_HIT_CNT_EN defined: 5 beats, 3 with any lane true -> hit_cnt=3; force 65540 hits -> 16'hFFFF;
//    undefined -> 0.

Source files
------------

// File: rtl/cmp_lanes_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_pkg
//  Purpose  : Shared types and constants for the cmp_lanes_pipe comparator
//             slice: comparator op encoding and the hit counter width.
//  Revision : 1.0  initial release
// ============================================================================
package cmp_pkg;

    // Comparator relation selector; codes 6 and 7 are reserved and yield 0.
    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NEQ = 3'd1,
        CMP_LT  = 3'd2,
        CMP_LE  = 3'd3,
        CMP_GT  = 3'd4,
        CMP_GE  = 3'd5
    } cmp_op_t;

    localparam int CMP_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/cmp_lanes_pipe_lane.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_lane
//  Purpose  : One combinational W-bit comparator lane. Evaluates a OP b with
//             either two's-complement or unsigned ordering; reserved op codes
//             produce 0.
//  Revision : 1.0  initial release
// ============================================================================
module cmp_lane
    import cmp_pkg::*;
#(
    parameter int W      = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [2:0]   op_i,
    output logic         res_o
);

    logic w_eq;
    logic w_lt;

    assign w_eq = (a_i == b_i);

    // Ordering is the only part that depends on signedness.
    generate
        if (SIGNED) begin : g_signed
            assign w_lt = ($signed(a_i) < $signed(b_i));
        end else begin : g_unsigned
            assign w_lt = (a_i < b_i);
        end
    endgenerate

    // Map the selected relation onto the eq/lt primitives.
    always_comb begin
        res_o = 1'b0;
        case (op_i)
            CMP_EQ:  res_o = w_eq;
            CMP_NEQ: res_o = ~w_eq;
            CMP_LT:  res_o = w_lt;
            CMP_LE:  res_o = w_lt | w_eq;
            CMP_GT:  res_o = ~(w_lt | w_eq);
            CMP_GE:  res_o = ~w_lt;
            default: res_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cmp_lanes_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_lanes_pipe
//  Purpose  : LANES independent W-bit comparators with a run-time selected
//             relation, a LAT-stage valid-tracked pipeline and a global stall
//             enable. Optional saturating hit counter enabled by the macro
//             CMP_HIT_CNT_EN (hit_cnt tied to zero when undefined).
//  Revision : 1.0  initial release
// ============================================================================
module cmp_lanes_pipe
    import cmp_pkg::*;
#(
    parameter int W      = 8,
    parameter int LANES  = 4,
    parameter int LAT    = 1,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [2:0]           op,
    input  logic [LANES*W-1:0]   a,
    input  logic [LANES*W-1:0]   b,
    output logic                 out_valid,
    output logic [LANES-1:0]     y,
    output logic                 any_y,
    output logic [CMP_CNT_W-1:0] hit_cnt
);

    logic [LANES-1:0] w_res;

    // Stage LAT-1 is the output stage.
    logic [LAT-1:0]   vld_q;
    logic [LAT-1:0]   any_q;
    logic [LANES-1:0] y_q [LAT];

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            cmp_lane #(
                .W      (W),
                .SIGNED (SIGNED)
            ) u_lane (
                .a_i   (a[g*W +: W]),
                .b_i   (b[g*W +: W]),
                .op_i  (op),
                .res_o (w_res[g])
            );
        end
    endgenerate

    // Capture results into stage 0 and shift the rest; bubbles carry zeros.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
            any_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                y_q[i] <= '0;
            end
        end else if (en) begin
            vld_q[0] <= in_valid;
            any_q[0] <= in_valid & (|w_res);
            y_q[0]   <= in_valid ? w_res : '0;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                any_q[i] <= any_q[i-1];
                y_q[i]   <= y_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign any_y     = any_q[LAT-1];
    assign y         = y_q[LAT-1];

`ifdef CMP_HIT_CNT_EN
    // A hit is counted on the edge that moves a valid, any-true beat into the
    // output stage, so a stalled output is never counted twice.
    logic                 w_nxt_hit;
    logic [CMP_CNT_W-1:0] cnt_q;
    logic [CMP_CNT_W-1:0] cnt_d;

    generate
        if (LAT == 1) begin : g_hit_direct
            assign w_nxt_hit = in_valid & (|w_res);
        end else begin : g_hit_staged
            assign w_nxt_hit = any_q[LAT-2];
        end
    endgenerate

    // Saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (en && w_nxt_hit && (cnt_q != {CMP_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt = cnt_q;
`else
    assign hit_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmp_lanes_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmp_lanes_pipe
//  Purpose  : Directed self-checking bench for cmp_lanes_pipe using four
//             parameterisations sharing one clock and control inputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cmp_lanes_pipe;

`ifdef CMP_HIT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        en;
    logic        in_valid;
    logic [2:0]  op;
    logic [0:0]  a1, b1;
    logic [31:0] a8, b8;

    logic        d1_ov, d1_any;
    logic [0:0]  d1_y;
    logic [15:0] d1_hit;
    logic        d2_ov, d2_any, d3_ov, d3_any, d4_ov, d4_any;
    logic [3:0]  d2_y, d3_y, d4_y;
    logic [15:0] d2_hit, d3_hit, d4_hit;

    int pass_cnt;
    int chk_cnt;

    cmp_lanes_pipe #(.W(1), .LANES(1), .LAT(1), .SIGNED(1'b0)) d1 (
        .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .op(op),
        .a(a1), .b(b1), .out_valid(d1_ov), .y(d1_y), .any_y(d1_any), .hit_cnt(d1_hit));
    cmp_lanes_pipe #(.W(8), .LANES(4), .LAT(1), .SIGNED(1'b1)) d2 (
        .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .op(op),
        .a(a8), .b(b8), .out_valid(d2_ov), .y(d2_y), .any_y(d2_any), .hit_cnt(d2_hit));
    cmp_lanes_pipe #(.W(8), .LANES(4), .LAT(1), .SIGNED(1'b0)) d3 (
        .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .op(op),
        .a(a8), .b(b8), .out_valid(d3_ov), .y(d3_y), .any_y(d3_any), .hit_cnt(d3_hit));
    cmp_lanes_pipe #(.W(8), .LANES(4), .LAT(3), .SIGNED(1'b0)) d4 (
        .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .op(op),
        .a(a8), .b(b8), .out_valid(d4_ov), .y(d4_y), .any_y(d4_any), .hit_cnt(d4_hit));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge and settle before sampling.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; en = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Lanes {3,2,1,0}: (05,05) (80,7F) (01,FF) (FF,01)
    task automatic set_mixed;
        a8 = {8'h05, 8'h80, 8'h01, 8'hFF};
        b8 = {8'h05, 8'h7F, 8'hFF, 8'h01};
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b0; in_valid = 1'b1; op = 3'd1;
        a1 = 1'b1; b1 = 1'b0; set_mixed();
        tick();
        chk_cnt++;
        if ({d1_ov, d1_y, d1_any, d1_hit} !== 19'd0) $display("FAIL reset_d1 got %h want 0", {d1_ov, d1_y, d1_any, d1_hit});
        else pass_cnt++;
        chk_cnt++;
        if ({d2_ov, d2_y, d2_any, d2_hit} !== 22'd0) $display("FAIL reset_d2 got %h want 0", {d2_ov, d2_y, d2_any, d2_hit});
        else pass_cnt++;
        chk_cnt++;
        if ({d4_ov, d4_y, d4_any, d4_hit} !== 22'd0) $display("FAIL reset_d4 got %h want 0", {d4_ov, d4_y, d4_any, d4_hit});
        else pass_cnt++;
        reset = 1'b0;
    endtask

    // Legacy 1-bit neq behaviour, one cycle latency.
    task automatic test_neq_legacy;
        logic [1:0] va [4];
        logic       ey [4];
        va[0] = 2'b00; va[1] = 2'b10; va[2] = 2'b01; va[3] = 2'b11;
        ey[0] = 1'b0;  ey[1] = 1'b1;  ey[2] = 1'b1;  ey[3] = 1'b0;
        do_reset();
        op = 3'd1; in_valid = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = va[i];
            tick();
            chk_cnt++;
            if (d1_ov !== 1'b1 || d1_y[0] !== ey[i] || d1_any !== ey[i])
                $display("FAIL neq_legacy[%0d] got v=%b y=%b any=%b want v=1 y=%b", i, d1_ov, d1_y, d1_any, ey[i]);
            else pass_cnt++;
        end
    endtask

    // All six relations, signed (d2) and unsigned (d3), plus reserved codes.
    task automatic test_ops;
        logic [3:0] es [8];
        logic [3:0] eu [8];
        es[0] = 4'b1000; es[1] = 4'b0111; es[2] = 4'b0101; es[3] = 4'b1101;
        es[4] = 4'b0010; es[5] = 4'b1010; es[6] = 4'b0000; es[7] = 4'b0000;
        eu[0] = 4'b1000; eu[1] = 4'b0111; eu[2] = 4'b0010; eu[3] = 4'b1010;
        eu[4] = 4'b0101; eu[5] = 4'b1101; eu[6] = 4'b0000; eu[7] = 4'b0000;
        do_reset();
        set_mixed(); in_valid = 1'b1; en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            op = 3'(k);
            tick();
            chk_cnt++;
            if (d2_ov !== 1'b1 || d2_y !== es[k] || d2_any !== (|es[k]))
                $display("FAIL op_signed[%0d] got v=%b y=%b any=%b want v=1 y=%b", k, d2_ov, d2_y, d2_any, es[k]);
            else pass_cnt++;
            chk_cnt++;
            if (d3_ov !== 1'b1 || d3_y !== eu[k] || d3_any !== (|eu[k]))
                $display("FAIL op_unsigned[%0d] got v=%b y=%b any=%b want v=1 y=%b", k, d3_ov, d3_y, d3_any, eu[k]);
            else pass_cnt++;
        end
        a8 = {4{8'h80}}; b8 = {4{8'h80}}; op = 3'd5;
        tick();
        chk_cnt++;
        if (d2_y !== 4'b1111 || d3_y !== 4'b1111)
            $display("FAIL ge_equal_80 got s=%b u=%b want 1111", d2_y, d3_y);
        else pass_cnt++;
    endtask

    // LAT=3, four back-to-back beats then bubbles.
    task automatic test_back_to_back;
        logic [2:0] bop [4];
        logic [3:0] ey  [4];
        logic       ev;
        logic [3:0] eyy;
        bop[0] = 3'd0; bop[1] = 3'd1; bop[2] = 3'd2; bop[3] = 3'd5;
        ey[0] = 4'b1000; ey[1] = 4'b0111; ey[2] = 4'b0010; ey[3] = 4'b1101;
        do_reset();
        set_mixed();
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin in_valid = 1'b1; op = bop[c]; end
            else       begin in_valid = 1'b0; op = 3'd1; end
            tick();
            ev  = (c >= 2 && c <= 5);
            eyy = ev ? ey[c-2] : 4'b0000;
            chk_cnt++;
            if (d4_ov !== ev || d4_y !== eyy || d4_any !== (|eyy))
                $display("FAIL b2b[%0d] got v=%b y=%b any=%b want v=%b y=%b", c, d4_ov, d4_y, d4_any, ev, eyy);
            else pass_cnt++;
        end
    endtask

    // LAT=3 with a two-cycle stall while a beat sits on the output.
    task automatic test_stall;
        logic       cen [9];
        logic       civ [9];
        logic [2:0] cop [9];
        logic       ev  [9];
        logic [3:0] ey  [9];
        for (int c = 0; c < 9; c++) begin
            cen[c] = 1'b1; civ[c] = 1'b0; cop[c] = 3'd0;
        end
        civ[0] = 1'b1; cop[0] = 3'd0;
        civ[1] = 1'b1; cop[1] = 3'd1;
        civ[2] = 1'b1; cop[2] = 3'd6;
        cen[3] = 1'b0; civ[3] = 1'b1; cop[3] = 3'd5;
        cen[4] = 1'b0; civ[4] = 1'b1; cop[4] = 3'd5;
        civ[5] = 1'b1; cop[5] = 3'd2;
        ev[0] = 0; ev[1] = 0; ev[2] = 1; ev[3] = 1; ev[4] = 1; ev[5] = 1; ev[6] = 1; ev[7] = 1; ev[8] = 0;
        ey[0] = 4'b0000; ey[1] = 4'b0000; ey[2] = 4'b1000; ey[3] = 4'b1000; ey[4] = 4'b1000;
        ey[5] = 4'b0111; ey[6] = 4'b0000; ey[7] = 4'b0010; ey[8] = 4'b0000;
        do_reset();
        set_mixed();
        for (int c = 0; c < 9; c++) begin
            en = cen[c]; in_valid = civ[c]; op = cop[c];
            tick();
            chk_cnt++;
            if (d4_ov !== ev[c] || d4_y !== ey[c] || d4_any !== (|ey[c]))
                $display("FAIL stall[%0d] got v=%b y=%b any=%b want v=%b y=%b", c, d4_ov, d4_y, d4_any, ev[c], ey[c]);
            else pass_cnt++;
        end
        en = 1'b1;
    endtask

    // Reset with two beats in flight.
    task automatic test_reset_midflight;
        do_reset();
        set_mixed(); op = 3'd1; in_valid = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_cnt++;
        if (d4_ov !== 1'b0 || d4_y !== 4'b0000 || d4_hit !== 16'd0)
            $display("FAIL reset_midflight got v=%b y=%b hit=%h want 0", d4_ov, d4_y, d4_hit);
        else pass_cnt++;
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_cnt++;
            if (d4_ov !== 1'b0 || d4_y !== 4'b0000)
                $display("FAIL no_stale[%0d] got v=%b y=%b want v=0 y=0000", c, d4_ov, d4_y);
            else pass_cnt++;
        end
    endtask

    // Hit counter: 3 hits out of 5 beats, then saturation, then reset clear.
    task automatic test_hit_cnt;
        logic [2:0] hop [5];
        hop[0] = 3'd0; hop[1] = 3'd7; hop[2] = 3'd1; hop[3] = 3'd6; hop[4] = 3'd2;
        do_reset();
        set_mixed(); en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = hop[i];
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk_cnt++;
        if (d2_hit !== (CNT_ON ? 16'd3 : 16'd0))
            $display("FAIL hit_cnt_lat1 got %0d want %0d", d2_hit, CNT_ON ? 3 : 0);
        else pass_cnt++;
        chk_cnt++;
        if (d4_hit !== (CNT_ON ? 16'd3 : 16'd0))
            $display("FAIL hit_cnt_lat3 got %0d want %0d", d4_hit, CNT_ON ? 3 : 0);
        else pass_cnt++;
        in_valid = 1'b1; op = 3'd1;
        repeat (65531) tick();
        chk_cnt++;
        if (d2_hit !== (CNT_ON ? 16'hFFFE : 16'd0))
            $display("FAIL hit_cnt_near_sat got %h want %h", d2_hit, CNT_ON ? 16'hFFFE : 16'h0);
        else pass_cnt++;
        repeat (9) tick();
        chk_cnt++;
        if (d2_hit !== (CNT_ON ? 16'hFFFF : 16'd0))
            $display("FAIL hit_cnt_sat got %h want %h", d2_hit, CNT_ON ? 16'hFFFF : 16'h0);
        else pass_cnt++;
        do_reset();
        chk_cnt++;
        if (d2_hit !== 16'd0)
            $display("FAIL hit_cnt_clear got %h want 0000", d2_hit);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        reset = 1'b1; en = 1'b0; in_valid = 1'b0; op = 3'd0;
        a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0;
        test_reset();
        test_neq_legacy();
        test_ops();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_hit_cnt();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
